// File: rtl/alu_pkg.sv
// Opcode encodings, FSM state constants and opcode-class helpers shared by the
// ALU/MDU top and its iterative multiply/divide unit.
package alu_pkg;

  typedef enum logic [4:0] {
    ADD   = 5'b00000, SUB   = 5'b00001, ADDU  = 5'b00010, SUBU = 5'b00011,
    SLT   = 5'b00100, SLTU  = 5'b00101,
    MULT  = 5'b01100, MULTU = 5'b01101, DIV   = 5'b01110, DIVU = 5'b01111,
    AND   = 5'b10000, OR    = 5'b10001, XOR   = 5'b10010, NOR  = 5'b10011,
    SLL   = 5'b10100, SRL   = 5'b10101, SRA   = 5'b10110
  } alu_op_e;

  typedef logic [1:0] state_e;
  localparam state_e IDLE = 2'd0;
  localparam state_e EXEC = 2'd1;
  localparam state_e DONE = 2'd2;

  function automatic logic is_muldiv(input alu_op_e op);
    return op inside {MULT, MULTU, DIV, DIVU};
  endfunction

  function automatic logic is_div(input alu_op_e op);
    return op inside {DIV, DIVU};
  endfunction

  function automatic logic sets_flags(input alu_op_e op);
    return op inside {ADD, SUB, ADDU, SUBU, SLT, SLTU, MULT, MULTU, DIV, DIVU};
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative multiply / restoring divide on operand magnitudes, one bit
// per cycle; signs are re-applied on the final iteration so lo/hi are final when done.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  input  logic             is_div,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d, div_q, div_d, negq_q, negq_d, negr_q, negr_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [WIDTH-1:0]   a_mag, b_mag, nh, nl;
  logic [WIDTH:0]     sum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod;
  logic               last;

  always_comb begin
    a_mag  = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag  = (sgn && b[WIDTH-1]) ? -b : b;
    last   = busy_q && (cnt_q == LAST);
    rem_sh = {hi_q, lo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, m_q};
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    prod   = {sum, lo_q[WIDTH-1:1]};
    if (div_q) begin
      // lo shifts the dividend out at the top and the quotient in at the bottom
      nh = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      nl = {lo_q[WIDTH-2:0], !diff[WIDTH]};
    end else begin
      nh = prod[2*WIDTH-1:WIDTH];
      nl = prod[WIDTH-1:0];
    end
    if (last) begin
      if (div_q) begin
        if (negq_q) nl = -nl;
        if (negr_q) nh = -nh;
      end else if (negq_q) begin
        {nh, nl} = -{nh, nl};
      end
    end

    cnt_d  = cnt_q;
    busy_d = busy_q;
    div_d  = div_q;
    negq_d = negq_q;
    negr_d = negr_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    m_d    = m_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      div_d  = is_div;
      negq_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      negr_d = sgn && a[WIDTH-1];
      m_d    = is_div ? b_mag : a_mag;
      lo_d   = is_div ? a_mag : b_mag;
      hi_d   = '0;
    end else if (busy_q) begin
      hi_d   = nh;
      lo_d   = nl;
      cnt_d  = last ? '0 : cnt_q + 1'b1;
      busy_d = !last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      m_q    <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      div_q  <= div_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      m_q    <= m_d;
    end
  end

  assign busy = busy_q;
  assign done = last;
  assign hi   = nh;
  assign lo   = nl;
endmodule

// File: rtl/alu_mdu.sv
// ALU with iterative MDU: single-cycle ops resolve on accept, mul/div iterate
// in EXEC; results are registered and held in DONE until out_ready.
module alu_mdu import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             z,
  output logic             v,
  output logic             n,
  output logic             err
);
  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  alu_op_e          op_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d, hi_q, hi_d, r_y, r_hi, it_hi, it_lo;
  logic             z_q, z_d, v_q, v_d, n_q, n_d, err_q, err_d;
  logic             ovf_q, ovf_d, mdiv_q, mdiv_d;
  logic             r_v, r_err, flag_en, accept, go_iter, it_done, it_busy;
  logic [SW-1:0]    sh;

  assign op_e      = alu_op_e'(op);
  assign sh        = b[SW-1:0];
  assign in_ready  = (state_q == IDLE && !it_busy) || (state_q == DONE && out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  // divide by zero never enters EXEC; it resolves like a single-cycle op
  assign go_iter   = accept && is_muldiv(op_e) && !(is_div(op_e) && b == '0);
  assign flag_en   = sets_flags(op_e) && !is_muldiv(op_e);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk), .rst_n(reset_n), .start(go_iter), .a(a), .b(b),
    .sgn(op_e == MULT || op_e == DIV), .is_div(is_div(op_e)),
    .busy(it_busy), .done(it_done), .hi(it_hi), .lo(it_lo)
  );

  always_comb begin
    r_y   = '0;
    r_hi  = '0;
    r_v   = 1'b0;
    r_err = 1'b0;
    case (op_e)
      ADD:   begin r_y = a + b; r_v = (a[M] == b[M]) && (r_y[M] != a[M]); end
      SUB:   begin r_y = a - b; r_v = (a[M] != b[M]) && (r_y[M] != a[M]); end
      ADDU:  r_y = a + b;
      SUBU:  r_y = a - b;
      SLT:   r_y = {{M{1'b0}}, $signed(a) < $signed(b)};
      SLTU:  r_y = {{M{1'b0}}, a < b};
      AND:   r_y = a & b;
      OR:    r_y = a | b;
      XOR:   r_y = a ^ b;
      NOR:   r_y = ~(a | b);
      SLL:   r_y = a << sh;
      SRL:   r_y = a >> sh;
      SRA:   r_y = $signed(a) >>> sh;
      DIV, DIVU: begin r_y = '1; r_hi = a; r_err = 1'b1; end
      MULT, MULTU: r_y = '0;
      default: r_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    hi_d    = hi_q;
    z_d     = z_q;
    v_d     = v_q;
    n_d     = n_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    mdiv_d  = mdiv_q;
    if (state_q == EXEC && it_done) begin
      state_d = DONE;
      y_d     = it_lo;
      hi_d    = it_hi;
      v_d     = ovf_q;
      err_d   = 1'b0;
      z_d     = mdiv_q ? (it_lo == '0) : ({it_hi, it_lo} == '0);
      n_d     = mdiv_q ? it_lo[M] : it_hi[M];
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
    if (accept) begin
      if (go_iter) begin
        state_d = EXEC;
        mdiv_d  = is_div(op_e);
        ovf_d   = (op_e == DIV) && (a == {1'b1, {M{1'b0}}}) && (b == '1);
      end else begin
        state_d = DONE;
        y_d     = r_y;
        hi_d    = r_hi;
        v_d     = r_v;
        err_d   = r_err;
        z_d     = flag_en && (r_y == '0);
        n_d     = flag_en && r_y[M];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      hi_q    <= '0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      mdiv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      hi_q    <= hi_d;
      z_q     <= z_d;
      v_q     <= v_d;
      n_q     <= n_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      mdiv_q  <= mdiv_d;
    end
  end

  assign y   = y_q;
  assign hi  = hi_q;
  assign z   = z_q;
  assign v   = v_q;
  assign n   = n_q;
  assign err = err_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed corner cases plus random ops against an
// arithmetic reference model, with a second 8-bit instance.
module tb_alu_mdu;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] y;
    logic [31:0] hi;
    logic        z, v, n, err;
  } res_t;

  logic        clk = 1'b0, reset_n = 1'b0, out_ready = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, z, v, n, err;
  logic [4:0]  op = '0;
  logic [31:0] a = '0, b = '0, y, hi;
  logic        in_valid8 = 1'b0, in_ready8, out_valid8, z8, v8, n8, err8;
  logic [4:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0, y8, hi8;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .hi(hi), .z(z), .v(v), .n(n), .err(err));

  alu_mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready),
    .y(y8), .hi(hi8), .z(z8), .v(v8), .n(n8), .err(err8));

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want summary");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on the documented rules.
  function automatic res_t model(input logic [4:0] o, input logic [31:0] ia, ib);
    res_t r;
    longint sa, sb, s;
    logic [63:0] p;
    logic ar;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    r = '0;
    ar = 1'b0;
    s = 0;
    case (o)
      ADD:  begin s = sa + sb; r.y = s[31:0]; r.v = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000); ar = 1; end
      SUB:  begin s = sa - sb; r.y = s[31:0]; r.v = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000); ar = 1; end
      ADDU: begin r.y = ia + ib; ar = 1; end
      SUBU: begin r.y = ia - ib; ar = 1; end
      SLT:  begin r.y = (sa < sb) ? 32'd1 : 32'd0; ar = 1; end
      SLTU: begin r.y = (ia < ib) ? 32'd1 : 32'd0; ar = 1; end
      AND:  r.y = ia & ib;
      OR:   r.y = ia | ib;
      XOR:  r.y = ia ^ ib;
      NOR:  r.y = ~(ia | ib);
      SLL:  r.y = ia << ib[4:0];
      SRL:  r.y = ia >> ib[4:0];
      SRA:  begin s = sa >>> ib[4:0]; r.y = s[31:0]; end
      MULT, MULTU: begin
        if (o == MULT) p = sa * sb;
        else           p = {32'h0, ia} * {32'h0, ib};
        r.y = p[31:0]; r.hi = p[63:32]; r.z = (p == 0); r.n = p[63];
      end
      DIV, DIVU: begin
        if (ib == 0) begin
          r.y = 32'hFFFFFFFF; r.hi = ia; r.err = 1;
        end else if (o == DIV && ia == 32'h80000000 && ib == 32'hFFFFFFFF) begin
          r.y = ia; r.hi = 0; r.v = 1; r.n = 1;
        end else begin
          if (o == DIV) begin s = sa / sb; r.y = s[31:0]; s = sa % sb; r.hi = s[31:0]; end
          else begin r.y = ia / ib; r.hi = ia % ib; end
          r.z = (r.y == 0); r.n = r.y[31];
        end
      end
      default: r.err = 1;
    endcase
    if (ar) begin r.z = (r.y == 0); r.n = r.y[31]; end
    return r;
  endfunction

  // Issues one op and returns once out_valid is seen (or a bound expires).
  task automatic do_op(input logic [4:0] o, input logic [31:0] ia, ib, output int lat);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    op = o; a = ia; b = ib; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic do_op8(input logic [4:0] o, input logic [7:0] ia, ib, output int lat);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready8 && t < 200) begin @(negedge clk); t++; end
    op8 = o; a8 = ia; b8 = ib; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1;
    while (!out_valid8 && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, y, hi, z, v, n, err} !== 70'd0) begin
      n_bad++; $display("FAIL reset_outputs: got ov=%b y=%h hi=%h zvne=%b%b%b%b, want all 0", out_valid, y, hi, z, v, n, err);
    end
    @(negedge clk); reset_n = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_add_sub;
    int lat;
    do_op(ADD, 32'h7FFFFFFF, 32'h1, lat);
    n_cmp++;
    if ({y, z, v, n, err} !== {32'h80000000, 4'b0110} || lat !== 1) begin
      n_bad++; $display("FAIL add_ovf: got y=%h zvne=%b%b%b%b lat=%0d, want 80000000 0110 1", y, z, v, n, err, lat);
    end
    do_op(SUB, 32'd5, 32'd5, lat);
    n_cmp++;
    if ({y, z, v, n, err} !== {32'h0, 4'b1000}) begin
      n_bad++; $display("FAIL sub_zero: got y=%h zvne=%b%b%b%b, want 0 1000", y, z, v, n, err);
    end
  endtask

  task automatic test_mult;
    int lat, busy_bad;
    busy_bad = 0;
    @(negedge clk);
    op = MULT; a = 32'hFFFFFFFD; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready !== 1'b0) busy_bad++;
      @(posedge clk); #1; lat++;
    end
    n_cmp++;
    if (hi !== 32'hFFFFFFFF || y !== 32'hFFFFFFEB || n !== 1'b1 || z !== 1'b0 || lat !== 33) begin
      n_bad++; $display("FAIL mult_neg: got hi=%h y=%h n=%b lat=%0d, want FFFFFFFF FFFFFFEB 1 33", hi, y, n, lat);
    end
    n_cmp++;
    if (busy_bad !== 0) begin
      n_bad++; $display("FAIL mult_in_ready: got %0d cycles with in_ready high in EXEC, want 0", busy_bad);
    end
  endtask

  task automatic test_div;
    int lat;
    do_op(DIV, 32'hFFFFFFF9, 32'd2, lat);
    n_cmp++;
    if (y !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF || err !== 1'b0 || lat !== 33) begin
      n_bad++; $display("FAIL div_neg: got y=%h hi=%h err=%b lat=%0d, want FFFFFFFD FFFFFFFF 0 33", y, hi, err, lat);
    end
    do_op(DIVU, 32'h12345678, 32'd0, lat);
    n_cmp++;
    if ({y, hi, z, v, n, err} !== {32'hFFFFFFFF, 32'h12345678, 4'b0001} || lat !== 1) begin
      n_bad++; $display("FAIL div_by_zero: got y=%h hi=%h zvne=%b%b%b%b lat=%0d, want FFFFFFFF 12345678 0001 1", y, hi, z, v, n, err, lat);
    end
    do_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat);
    n_cmp++;
    if (y !== 32'h80000000 || hi !== 32'h0 || v !== 1'b1 || err !== 1'b0 || lat !== 33) begin
      n_bad++; $display("FAIL div_ovf: got y=%h hi=%h v=%b err=%b lat=%0d, want 80000000 0 1 0 33", y, hi, v, err, lat);
    end
  endtask

  task automatic test_backpressure;
    int lat, moved;
    logic [69:0] held;
    logic [31:0] xa;
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_op(SUB, 32'd4, 32'd9, lat);
    held = {y, hi, z, v, n, err, 2'b00};
    moved = 0;
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1; op = ADD; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      if ({y, hi, z, v, n, err, 2'b00} !== held || out_valid !== 1'b1) moved++;
    end
    n_cmp++;
    if (moved !== 0 || held !== {32'hFFFFFFFB, 32'h0, 4'b0010, 2'b00}) begin
      n_bad++; $display("FAIL hold_stable: got %0d changed cycles, held y=%h, want 0 and FFFFFFFB", moved, held[69:38]);
    end
    xa = $urandom;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; op = XOR; a = xa; b = xa;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || {y, hi, z, v, n, err} !== {64'h0, 4'b0000}) begin
      n_bad++; $display("FAIL xor_same_cycle: got ov=%b y=%h hi=%h zvne=%b%b%b%b, want 1 0 0 0000", out_valid, y, hi, z, v, n, err);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    op = MULTU; a = $urandom; b = $urandom; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, y, hi, z, v, n, err} !== 70'd0) begin
      n_bad++; $display("FAIL reset_mid: got ov=%b y=%h hi=%h, want 0 0 0", out_valid, y, hi);
    end
    @(negedge clk); reset_n = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
    do_op(ADD, 32'd2, 32'd3, lat);
    n_cmp++;
    if (y !== 32'd5 || lat !== 1) begin
      n_bad++; $display("FAIL add_after_reset: got y=%h lat=%0d, want 5 1", y, lat);
    end
  endtask

  task automatic test_random;
    logic [4:0] ops [17] = '{ADD, SUB, ADDU, SUBU, SLT, SLTU, MULT, MULTU, DIV, DIVU,
                             AND, OR, XOR, NOR, SLL, SRL, SRA};
    logic [4:0] ro;
    logic [31:0] ra, rb;
    res_t e;
    int lat, elat, k;
    for (int i = 0; i < 160; i++) begin
      k = int'($urandom_range(0, 17));
      ro = (k == 17) ? (5'b11000 | 5'($urandom_range(0, 7))) : ops[k];
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 0;
      if ($urandom_range(0, 9) == 0) rb = 32'($urandom_range(0, 40));
      if (ro == DIV && $urandom_range(0, 5) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      e = model(ro, ra, rb);
      elat = (ro inside {MULT, MULTU} || (ro inside {DIV, DIVU} && rb != 0)) ? 33 : 1;
      do_op(ro, ra, rb, lat);
      n_cmp++;
      if ({y, hi, z, v, n, err} !== e || lat !== elat) begin
        n_bad++;
        $display("FAIL random op=%b a=%h b=%h: got y=%h hi=%h zvne=%b%b%b%b lat=%0d, want y=%h hi=%h zvne=%b%b%b%b lat=%0d",
                 ro, ra, rb, y, hi, z, v, n, err, lat, e.y, e.hi, e.z, e.v, e.n, e.err, elat);
      end
    end
  endtask

  task automatic test_width8;
    int lat;
    do_op8(MULTU, 8'hFF, 8'hFF, lat);
    n_cmp++;
    if (hi8 !== 8'hFE || y8 !== 8'h01 || lat !== 9) begin
      n_bad++; $display("FAIL w8_multu: got hi=%h y=%h lat=%0d, want FE 01 9", hi8, y8, lat);
    end
    do_op8(SRA, 8'h80, 8'h03, lat);
    n_cmp++;
    if (y8 !== 8'hF0 || {z8, v8, n8, err8} !== 4'b0000) begin
      n_bad++; $display("FAIL w8_sra: got y=%h zvne=%b%b%b%b, want F0 0000", y8, z8, v8, n8, err8);
    end
    do_op8(5'b11111, 8'h12, 8'h34, lat);
    n_cmp++;
    if (err8 !== 1'b1 || y8 !== 8'h00 || hi8 !== 8'h00 || lat !== 1) begin
      n_bad++; $display("FAIL w8_undef: got err=%b y=%h hi=%h lat=%0d, want 1 00 00 1", err8, y8, hi8, lat);
    end
  endtask

  initial begin
    test_reset;
    test_add_sub;
    test_mult;
    test_div;
    test_backpressure;
    test_reset_mid;
    test_random;
    test_width8;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
